// File: rtl/rip_const_pkg.sv
// ---------------------------------------------------------------------------
// rip_const -- shared constants for the RIP load/store unit.
//   B_WIDTH    : byte lane width of the attached data BRAM
//   F3_*       : RV32 load/store funct3 encodings
//   lsu_state_t: LSU handshake FSM states
//   lsu_err    : decides whether a request is misaligned or illegal
// ---------------------------------------------------------------------------
package rip_const;

  localparam int B_WIDTH = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } lsu_state_t;

  // Stores only know SB/SH/SW; loads reject the three unused codes.
  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic lsu_err(input logic we, input logic [2:0] f3,
                                   input logic [1:0] lo);
    logic e;
    e = 1'b0;
    if (we) e = (f3 >= 3'b011);
    else    e = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((f3 == F3_LH || f3 == F3_LHU) && lo[0]) e = 1'b1;
    if (f3 == F3_LW && lo != 2'b00) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/rip_load_ext.sv
// ---------------------------------------------------------------------------
// rip_load_ext -- combinational load data extraction and extension.
//   word   : 32-bit word read from the BRAM
//   offset : byte offset within the word (addr[1:0] of the load)
//   funct3 : load type (LB/LH/LW/LBU/LHU)
//   data   : right-aligned, sign- or zero-extended load result
// ---------------------------------------------------------------------------
module rip_load_ext
  import rip_const::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [B_WIDTH-1:0]   sel_byte;
  logic [2*B_WIDTH-1:0] sel_half;

  always_comb begin
    sel_byte = '0;
    case (offset)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = offset[1] ? word[31:16] : word[15:0];
  end

  // Unknown funct3 values never reach here as valid data; they yield 0.
  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU: data = {24'd0, sel_byte};
      F3_LH:  data = {{16{sel_half[15]}}, sel_half};
      F3_LHU: data = {16'd0, sel_half};
      F3_LW:  data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/rip_lsu.sv
// ---------------------------------------------------------------------------
// rip_lsu -- RV32 load/store unit in front of a byte-write 32-bit BRAM.
//   clk, rstn         : clock, asynchronous active-low reset
//   req_*             : valid/ready request (we, funct3, byte addr, wdata, rd)
//   resp_*            : valid/ready response (rdata, rd tag, err)
//   mem_*             : BRAM port; mem_dout is valid the cycle after mem_en
// One response per request, in order, one cycle after accept. A stalled
// response is parked in a hold register so the BRAM output may change.
// ---------------------------------------------------------------------------
module rip_lsu
  import rip_const::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  lsu_state_t  state;
  logic [1:0]  r_offset;
  logic [2:0]  r_funct3;
  logic        r_store;
  logic        r_err;
  logic [4:0]  r_rd;
  logic [31:0] hold_rdata;
  logic [4:0]  hold_rd;
  logic        hold_err;

  logic        accept;
  logic        req_err;
  logic [3:0]  we_mask;
  logic [31:0] ext_data;
  logic [31:0] busy_rdata;
  logic        unused_addr_bits;

  // Address bits above the BRAM depth are dropped, so accesses wrap.
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // rstn gating keeps ready low throughout reset, not just after it.
  assign req_ready = rstn && ((state == ST_IDLE) ||
                              (state == ST_BUSY && resp_ready));
  assign accept    = req_valid && req_ready;
  assign req_err   = lsu_err(req_we, req_funct3, req_addr[1:0]);

  // Memory port is only active in the accept cycle of a legal request.
  always_comb begin
    we_mask = 4'b0000;
    mem_din = req_wdata;
    case (req_funct3)
      F3_SB: begin
        we_mask = 4'b0001 << req_addr[1:0];
        mem_din = {4{req_wdata[7:0]}};
      end
      F3_SH: begin
        we_mask = 4'b0011 << {req_addr[1], 1'b0};
        mem_din = {2{req_wdata[15:0]}};
      end
      default: begin
        we_mask = 4'b1111;
        mem_din = req_wdata;
      end
    endcase
  end

  assign mem_en   = accept && !req_err;
  assign mem_we   = (mem_en && req_we) ? we_mask : 4'b0000;
  assign mem_addr = req_addr[ADDR_WIDTH+1:2];

  rip_load_ext u_load_ext (
    .word   (mem_dout),
    .offset (r_offset),
    .funct3 (r_funct3),
    .data   (ext_data)
  );

  // Stores and faulted requests always answer with zero data.
  assign busy_rdata = (r_store || r_err) ? 32'd0 : ext_data;

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_rd    = '0;
    resp_err   = 1'b0;
    case (state)
      ST_BUSY: begin
        resp_valid = 1'b1;
        resp_rdata = busy_rdata;
        resp_rd    = r_rd;
        resp_err   = r_err;
      end
      ST_HOLD: begin
        resp_valid = 1'b1;
        resp_rdata = hold_rdata;
        resp_rd    = hold_rd;
        resp_err   = hold_err;
      end
      default: ;
    endcase
  end

  // Handshake FSM: captures request attributes on accept and parks the
  // formatted response when the consumer stalls in BUSY.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      r_offset   <= '0;
      r_funct3   <= '0;
      r_store    <= 1'b0;
      r_err      <= 1'b0;
      r_rd       <= '0;
      hold_rdata <= '0;
      hold_rd    <= '0;
      hold_err   <= 1'b0;
    end else begin
      if (accept) begin
        r_offset <= req_addr[1:0];
        r_funct3 <= req_funct3;
        r_store  <= req_we;
        r_err    <= req_err;
        r_rd     <= req_rd;
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (resp_ready) begin
            state <= accept ? ST_BUSY : ST_IDLE;
          end else begin
            hold_rdata <= busy_rdata;
            hold_rd    <= r_rd;
            hold_err   <= r_err;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_lsu.sv
// ---------------------------------------------------------------------------
// tb_rip_lsu -- directed bench for rip_lsu with a behavioural byte-write
// BRAM (registered read) attached to the memory port.
// ---------------------------------------------------------------------------
module tb_rip_lsu;
  import rip_const::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic [4:0]    resp_rd;
  logic          resp_err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  logic [31:0]   bram [0:(1<<AW)-1];
  int            check_count = 0;
  int            error_count = 0;

  always #5 clk = ~clk;

  rip_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Byte-write BRAM with a registered read port.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      if (mem_we == 4'b0000) mem_dout <= bram[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs just after the falling edge, then waits 1ns
  // so combinational outputs can be sampled well away from the rising edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic rr);
    @(negedge clk);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    resp_ready = rr;
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) bram[i] = 32'd0;
    mem_dout   = 32'd0;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 5'd0;
    resp_ready = 1'b1;

    #12;
    checkOutput("rst_req_ready",  req_ready,  0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_rdata", resp_rdata, 0);
    checkOutput("rst_resp_rd",    resp_rd,    0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("post_rst_ready", req_ready, 1);

    // Store word then load it back-to-back.
    applyStimulus(1, 1, F3_SW, 32'h10, 32'hDEADBEEF, 5'd0, 1);
    checkOutput("sw_mem_en",   mem_en,   1);
    checkOutput("sw_mem_we",   mem_we,   4'b1111);
    checkOutput("sw_mem_addr", mem_addr, 4);
    checkOutput("sw_mem_din",  mem_din,  32'hDEADBEEF);
    applyStimulus(1, 0, F3_LW, 32'h10, 32'h0, 5'd5, 1);
    checkOutput("sw_resp_valid", resp_valid, 1);
    checkOutput("sw_resp_rdata", resp_rdata, 0);
    checkOutput("sw_resp_err",   resp_err,   0);
    checkOutput("lw_mem_we",     mem_we,     0);
    applyStimulus(0, 0, F3_LW, 32'h0, 32'h0, 5'd0, 1);
    checkOutput("lw_rdata", resp_rdata, 32'hDEADBEEF);
    checkOutput("lw_rd",    resp_rd,    5);

    // Byte store to lane 3 with signed and unsigned readback.
    applyStimulus(1, 1, F3_SB, 32'h13, 32'h00000080, 5'd1, 1);
    checkOutput("idle_resp_valid", resp_valid, 0);
    checkOutput("sb_mem_we",  mem_we,  4'b1000);
    checkOutput("sb_mem_din", mem_din, 32'h80808080);
    applyStimulus(1, 0, F3_LB, 32'h13, 32'h0, 5'd2, 1);
    checkOutput("sb_resp_rd", resp_rd, 1);
    applyStimulus(1, 0, F3_LBU, 32'h13, 32'h0, 5'd3, 1);
    checkOutput("lb_rdata", resp_rdata, 32'hFFFFFF80);
    checkOutput("lb_rd",    resp_rd,    2);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1);
    checkOutput("lbu_rdata", resp_rdata, 32'h00000080);
    checkOutput("lbu_rd",    resp_rd,    3);

    // Halfword store to upper half; word 4 becomes 0x1234BEEF.
    applyStimulus(1, 1, F3_SH, 32'h12, 32'hFFFF1234, 5'd1, 1);
    checkOutput("sh_mem_we",  mem_we,  4'b1100);
    checkOutput("sh_mem_din", mem_din, 32'h12341234);
    applyStimulus(1, 0, F3_LHU, 32'h12, 32'h0, 5'd2, 1);
    applyStimulus(1, 0, F3_LH, 32'h10, 32'h0, 5'd3, 1);
    checkOutput("lhu_rdata", resp_rdata, 32'h00001234);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1);
    checkOutput("lh_rdata", resp_rdata, 32'hFFFFBEEF);

    // Misaligned halfword load and illegal funct3.
    applyStimulus(1, 0, F3_LH, 32'h11, 32'h0, 5'd4, 1);
    checkOutput("mis_mem_en", mem_en, 0);
    applyStimulus(1, 0, 3'b111, 32'h0, 32'h0, 5'd6, 1);
    checkOutput("mis_resp_err",   resp_err,   1);
    checkOutput("mis_resp_rdata", resp_rdata, 0);
    checkOutput("mis_resp_rd",    resp_rd,    4);
    checkOutput("ill_mem_en",     mem_en,     0);
    applyStimulus(1, 1, F3_SW, 32'h12, 32'h55555555, 5'd7, 1);
    checkOutput("ill_resp_err", resp_err, 1);
    checkOutput("ill_resp_rd",  resp_rd,  6);
    checkOutput("missw_mem_we", mem_we,   0);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1);
    checkOutput("missw_resp_err", resp_err, 1);

    // Back-pressure: second response stalled for three cycles.
    applyStimulus(1, 0, F3_LW, 32'h10, 32'h0, 5'd7, 1);
    checkOutput("bp_accept1", req_ready, 1);
    applyStimulus(1, 0, F3_LBU, 32'h11, 32'h0, 5'd8, 1);
    checkOutput("bp_r1_rdata", resp_rdata, 32'h1234BEEF);
    checkOutput("bp_r1_rd",    resp_rd,    7);
    applyStimulus(1, 0, F3_LB, 32'h12, 32'h0, 5'd9, 0);
    checkOutput("bp_busy_ready", req_ready,  0);
    checkOutput("bp_busy_en",    mem_en,     0);
    checkOutput("bp_r2_rdata",   resp_rdata, 32'h000000BE);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, F3_LB, 32'h12, 32'h0, 5'd9, 0);
      checkOutput("bp_hold_valid", resp_valid, 1);
      checkOutput("bp_hold_ready", req_ready,  0);
      checkOutput("bp_hold_rdata", resp_rdata, 32'h000000BE);
      checkOutput("bp_hold_rd",    resp_rd,    8);
    end
    applyStimulus(1, 0, F3_LB, 32'h12, 32'h0, 5'd9, 1);
    checkOutput("bp_rel_ready", req_ready,  0);
    checkOutput("bp_rel_rdata", resp_rdata, 32'h000000BE);
    applyStimulus(1, 0, F3_LB, 32'h12, 32'h0, 5'd9, 1);
    checkOutput("bp_idle_valid", resp_valid, 0);
    checkOutput("bp_idle_en",    mem_en,     1);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1);
    checkOutput("bp_r3_rdata", resp_rdata, 32'h00000034);
    checkOutput("bp_r3_rd",    resp_rd,    9);

    // Address wrap beyond BRAM depth.
    applyStimulus(1, 0, F3_LW, 32'h1000, 32'h0, 5'd10, 1);
    checkOutput("wrap_mem_addr", mem_addr, 0);
    checkOutput("wrap_mem_en",   mem_en,   1);
    applyStimulus(1, 0, F3_LW, 32'h1010, 32'h0, 5'd11, 1);
    checkOutput("wrap_rdata",     resp_rdata, 0);
    checkOutput("wrap2_mem_addr", mem_addr,   4);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1);
    checkOutput("wrap2_rdata", resp_rdata, 32'h1234BEEF);

    // Reset while holding a response.
    applyStimulus(1, 0, F3_LW, 32'h10, 32'h0, 5'd12, 0);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
    checkOutput("hold_before_rst", resp_valid, 1);
    checkOutput("hold_rd_before",  resp_rd,    12);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("rst_hold_valid", resp_valid, 0);
    checkOutput("rst_hold_ready", req_ready,  0);
    checkOutput("rst_hold_rd",    resp_rd,    0);
    @(negedge clk);
    rstn       = 1'b1;
    resp_ready = 1'b1;
    #1;
    checkOutput("rel_ready", req_ready,  1);
    checkOutput("rel_valid", resp_valid, 0);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1);
    checkOutput("rel_no_stale", resp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
